// File: rtl/fib_arb_pkg.sv
// Shared definitions for the Fibonacci engine request arbiter.
// Holds the FSM state encoding, default index/result widths and the largest
// index whose Fibonacci number still fits a 20-bit result.
package fib_arb_pkg;

    localparam int IDX_W_DEF     = 5;
    localparam int F_W_DEF       = 20;
    localparam int MAX_INDEX_20B = 30;   // F(30)=832040 fits 20 bits, F(31) does not
    localparam int TIMEOUT_DEF   = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin picker.
// Ports: req (request vector), ptr (last winner; search starts at ptr+1 with wrap),
//        grant (one-hot), grant_idx (binary index of grant), any_grant.
module rr_arbiter
    import fib_arb_pkg::*;
#(
    parameter int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any_grant
);

    int k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        k         = 0;
        // Walk ptr+1, ptr+2, ... ptr+N (mod N); the last slot checked is the
        // previous winner itself, so it only wins when nobody else asks.
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!any_grant && req[k]) begin
                grant[k]  = 1'b1;
                grant_idx = PW'(k);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fib_request_arbiter.sv
// Shares one external Fibonacci engine between N_REQ requesters, round-robin.
// Ports: clk/rst (sync, active-high); req_valid/req_idx/req_ready request side;
//        resp_valid/resp_f/resp_err response side; busy; eng_* engine handshake.
// One request in flight; out-of-range indices rejected locally; WAIT watchdog.
module fib_request_arbiter
    import fib_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int F_W       = F_W_DEF,
    parameter int MAX_INDEX = MAX_INDEX_20B,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*IDX_W-1:0] req_idx,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [F_W-1:0]         resp_f,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   eng_start,
    output logic [IDX_W-1:0]       eng_i,
    input  logic                   eng_ready,
    input  logic                   eng_done,
    input  logic [F_W-1:0]         eng_f
);

    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [PW-1:0]     last_owner;
    logic [PW-1:0]     owner;
    logic [IDX_W-1:0]  idx_q;
    logic [F_W-1:0]    result_q;
    logic              err_q;
    logic [WD_W-1:0]   wdog;

    logic [N_REQ-1:0]  arb_grant;
    logic [PW-1:0]     arb_idx;
    logic              arb_any;
    logic [IDX_W-1:0]  grant_idx_val;
    logic              grant_reject;
    logic              wdog_expired;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (last_owner),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    assign grant_idx_val = req_idx[int'(arb_idx)*IDX_W +: IDX_W];
    assign grant_reject  = int'(grant_idx_val) > MAX_INDEX;
    assign wdog_expired  = (wdog == WD_W'(TIMEOUT - 1));
    assign eng_i         = idx_q;

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = '0;
        resp_f     = '0;
        resp_err   = 1'b0;
        eng_start  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                // Grant suppressed during reset so nothing appears transferred.
                if (arb_any && !rst) begin
                    req_ready = arb_grant;
                    state_nxt = grant_reject ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                eng_start = eng_ready;
                if (eng_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (eng_done || wdog_expired) state_nxt = RESP;
            end
            RESP: begin
                resp_valid[owner] = 1'b1;
                resp_f            = result_q;
                resp_err          = err_q;
                state_nxt         = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= PW'(N_REQ - 1);   // requester 0 searched first
            owner      <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            err_q      <= 1'b0;
            wdog       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        owner    <= arb_idx;
                        idx_q    <= grant_idx_val;
                        err_q    <= grant_reject;
                        result_q <= '0;
                    end
                end
                ISSUE: begin
                    if (eng_ready) wdog <= '0;
                end
                WAIT: begin
                    if (wdog != '1) wdog <= wdog + 1'b1;
                    // done wins over the watchdog when both land together
                    if (eng_done) begin
                        result_q <= eng_f;
                        err_q    <= 1'b0;
                    end else if (wdog_expired) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end
                end
                RESP: begin
                    last_owner <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule
